serial_sub_arbiter: RTL and testbench
=====================================

SERIAL_SUB_ARBITER -- requirements
Module: serial_sub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 1 to 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 presents operands.
REQ-005 SHALL have port req0_ready, output, 1, requester 0 operands accepted this cycle.
REQ-006 SHALL have ports req0_a and req0_b, input, WIDTH each, requester 0 minuend and subtrahend.
REQ-007 SHALL have ports req1_valid (input, 1), req1_ready (output, 1), req1_a and req1_b (input, WIDTH each), defined identically for requester 1.
REQ-008 SHALL have port res_valid, output, 1, a result is presented.
REQ-009 SHALL have port res_ready, input, 1, the consumer accepts the result.
REQ-010 SHALL have port res_diff, output, WIDTH, the difference (a - b) mod 2^WIDTH.
REQ-011 SHALL have port res_borr, output, 1, the final borrow (1 iff a < b, unsigned).
REQ-012 SHALL have port res_id, output, 1, index of the requester that owns the result.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE, grant when any reqN_valid is high: at most one reqN_ready is high, combinationally, in the same cycle.
REQ-016 SHALL arbitrate round-robin: if both requesters are valid, grant the one not granted last; a single valid requester is always granted.
REQ-017 SHALL capture a, b and the requester id on the handshake cycle (valid and ready both high), then enter RUN.
REQ-018 SHALL ignore requester input changes after capture.
REQ-019 SHALL, in RUN, process one bit per cycle, LSB first, for exactly WIDTH cycles.
  - Per-bit datapath: two cascaded half subtractors.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - The borrow register is cleared to 0 at capture.
REQ-020 SHALL enter DONE after the WIDTH-th RUN cycle, asserting res_valid exactly WIDTH+1 cycles after the handshake cycle.
REQ-021 SHALL hold res_valid, res_diff, res_borr and res_id stable in DONE until res_ready is high, then return to IDLE on the next edge.
REQ-022 SHALL keep both reqN_ready low in RUN and DONE; the minimum request-to-request spacing is WIDTH+2 cycles.
REQ-023 SHALL drive res_valid low outside DONE; res_diff, res_borr and res_id retain their last values outside DONE.
REQ-024 SHALL, if res_ready is high on the first DONE cycle, complete the transfer in that cycle.
REQ-025 SHALL operate identically for WIDTH=1: one RUN cycle, with res_borr = ~a & b.

Reset
REQ-026 SHALL, on rst_n low at a clock edge, enter IDLE with:
  - res_valid=0, res_diff=0, res_borr=0, res_id=0, busy=0;
  - internal shift registers and borrow register cleared;
  - the round-robin pointer set so requester 0 wins the first contention.
REQ-027 SHALL, on reset during RUN or DONE, abort the operation and discard the pending result; no res_valid follows.
REQ-028 SHALL hold reqN_ready low while rst_n is low.

Verification
REQ-029 SHALL pass (WIDTH=8): req0 a=0x05, b=0x03 -> res_valid 9 cycles after the handshake; res_diff=0x02, res_borr=0, res_id=0.
REQ-030 SHALL pass: req1 a=0x03, b=0x05 -> res_diff=0xFE, res_borr=1, res_id=1; edge cases 0x00-0x00 -> 0x00/0; 0x00-0xFF -> 0x01/1; 0xFF-0xFF -> 0x00/0.
REQ-031 SHALL pass: both valid continuously after reset, res_ready=1 -> grant order 0,1,0,1; handshakes exactly 10 cycles apart; each result matches its own requester's operands.
REQ-032 SHALL pass: res_ready held low 5 cycles in DONE -> res_valid and outputs stable for all 5 cycles, no new grant, busy=1; one cycle after res_ready rises, state is IDLE.
REQ-033 SHALL pass: rst_n low for 1 cycle at RUN bit 4 -> busy=0 and res_valid=0 next cycle; no stale result appears; the next request produces a correct result.
REQ-034 SHALL pass: a random 1000-operation run, compared against a reference model ((a-b) mod 256, a<b), with random valid and res_ready stalls -> zero mismatches.

Source files
------------

// File: rtl/serial_sub_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial (LSB-first) subtractor.
// The result is held in DONE until the consumer accepts it.
module serial_sub_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_borr,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             grant0;
    logic             grant1;
    logic             rr_last;
    logic             cur_id;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_next;
    logic             borr;
    logic [CNT_W-1:0] cnt;
    logic             hs1_d;
    logic             hs1_b;
    logic             bit_d;
    logic             bit_bout;

    // Two cascaded half subtractors on the current LSB
    always_comb begin
        hs1_d     = a_sh[0] ^ b_sh[0];
        hs1_b     = ~a_sh[0] & b_sh[0];
        bit_d     = hs1_d ^ borr;
        bit_bout  = hs1_b | (~hs1_d & borr);
        diff_next = (diff_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    end

    // Next-state and grant; requester 1 wins a tie only if 0 was granted last
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant1 = rst_n && req1_valid && (!req0_valid || !rr_last);
                grant0 = rst_n && req0_valid && !grant1;
                if (grant0 || grant1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            res_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Operand capture, serial shift and result latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            borr     <= 1'b0;
            cnt      <= '0;
            cur_id   <= 1'b0;
            rr_last  <= 1'b1;
            res_diff <= '0;
            res_borr <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_sh    <= grant1 ? req1_a : req0_a;
                        b_sh    <= grant1 ? req1_b : req0_b;
                        diff_sh <= '0;
                        borr    <= 1'b0;
                        cnt     <= '0;
                        cur_id  <= grant1;
                        rr_last <= grant1;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_next;
                    borr    <= bit_bout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        res_diff <= diff_next;
                        res_borr <= bit_bout;
                        res_id   <= cur_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Scoreboard bench for serial_sub_arbiter: handshakes push expected results,
// a negedge monitor pops and compares them when the result is presented.
module tb_serial_sub_arbiter;

    localparam int unsigned W = 8;
    localparam int TRAFFIC_LIMIT = 40000;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_diff;
    logic         res_borr;
    logic         res_id;
    logic         busy;

    typedef struct {
        logic [W-1:0] diff;
        bit           borr;
        bit           id;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           holding = 0;
    bit           expect_idle = 0;
    logic [W-1:0] held_diff;
    bit           held_borr;
    bit           held_id;
    logic [W-1:0] obs_diff;
    bit           obs_borr;
    bit           obs_id;

    serial_sub_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_diff   (res_diff),
        .res_borr   (res_borr),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name,
                       input longint unsigned act, input longint unsigned req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain modular subtraction and unsigned compare
    task automatic push_exp(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.diff = a - b;
        e.borr = (a < b);
        e.id   = id;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            holding     = 0;
            expect_idle = 0;
            chk(!req0_ready && !req1_ready, "ready_in_reset", {req0_ready, req1_ready}, 0);
        end else begin
            if (expect_idle) begin
                chk(!busy && !res_valid, "idle_after_xfer", {busy, res_valid}, 0);
                expect_idle = 0;
            end
            chk(!(req0_ready && req1_ready), "single_grant", {req0_ready, req1_ready}, 0);
            if (busy)
                chk(!req0_ready && !req1_ready, "no_grant_busy", {req0_ready, req1_ready}, 0);
            else
                chk((req0_ready || req1_ready) == (req0_valid || req1_valid), "idle_grant",
                    {req0_ready, req1_ready}, {req0_valid, req1_valid});
            if (req0_valid && req0_ready) push_exp(1'b0, req0_a, req0_b);
            if (req1_valid && req1_ready) push_exp(1'b1, req1_a, req1_b);
            if (res_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "spurious_result", {res_diff, res_borr, res_id}, 0);
                    end else begin
                        chk(res_diff == exp_q[0].diff, "res_diff", res_diff, exp_q[0].diff);
                        chk(res_borr == exp_q[0].borr, "res_borr", res_borr, exp_q[0].borr);
                        chk(res_id == exp_q[0].id, "res_id", res_id, exp_q[0].id);
                        chk(cyc - exp_q[0].cyc == W + 1, "latency", cyc - exp_q[0].cyc, W + 1);
                    end
                    held_diff = res_diff;
                    held_borr = res_borr;
                    held_id   = res_id;
                    holding   = 1;
                end else begin
                    chk(res_diff == held_diff && res_borr == held_borr && res_id == held_id && busy,
                        "hold_stable", {busy, res_diff, res_borr, res_id},
                        {1'b1, held_diff, held_borr, held_id});
                end
                if (res_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    obs_diff    = res_diff;
                    obs_borr    = res_borr;
                    obs_id      = res_id;
                    holding     = 0;
                    expect_idle = 1;
                end
            end else if (holding) begin
                chk(0, "valid_dropped", 0, 1);
                holding = 0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        sync();
        sync();
        rst_n = 1;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit hs = 0;
        int g = 0;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1; end
        while (!hs && g < 50) begin
            @(negedge clk);
            hs = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
            g++;
        end
        sync();
        if (id) req1_valid = 0; else req0_valid = 0;
        if (!hs) chk(0, "issue_timeout", g, 0);
    endtask

    task automatic wait_done();
        int g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while ((exp_q.size() != 0 || busy || holding) && g < 200);
        if (g >= 200) chk(0, "drain_timeout", exp_q.size(), 0);
        sync();
    endtask

    task automatic check_obs(input string name, input logic [W-1:0] d, input bit br, input bit id);
        chk(obs_diff == d && obs_borr == br && obs_id == id, name,
            {obs_diff, obs_borr, obs_id}, {d, br, id});
    endtask

    // contend=1: both always valid, res_ready=1, check alternation and spacing
    task automatic run_traffic(input int n_ops, input bit contend);
        int done_ops = 0;
        int guard = 0;
        int prev_id = -1;
        int prev_cyc = -1;
        bit hs0;
        bit hs1;
        req0_a = rand_opnd(); req0_b = rand_opnd();
        req1_a = rand_opnd(); req1_b = rand_opnd();
        req0_valid = contend ? 1'b1 : 1'($urandom_range(0, 1));
        req1_valid = contend ? 1'b1 : 1'($urandom_range(0, 1));
        res_ready  = contend ? 1'b1 : 1'($urandom_range(0, 1));
        while (done_ops < n_ops && guard < TRAFFIC_LIMIT) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0 || hs1) begin
                done_ops++;
                if (contend) begin
                    chk(int'(hs1) == ((prev_id < 0) ? 0 : 1 - prev_id), "rr_order",
                        hs1, (prev_id < 0) ? 0 : 1 - prev_id);
                    if (prev_cyc >= 0)
                        chk(cyc - prev_cyc == W + 2, "hs_spacing", cyc - prev_cyc, W + 2);
                    prev_id  = int'(hs1);
                    prev_cyc = cyc;
                end
            end
            sync();
            if (hs0) begin
                req0_a = rand_opnd(); req0_b = rand_opnd();
                req0_valid = contend ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else if (!req0_valid) begin
                req0_valid = ($urandom_range(0, 3) != 0);
            end
            if (hs1) begin
                req1_a = rand_opnd(); req1_b = rand_opnd();
                req1_valid = contend ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else if (!req1_valid) begin
                req1_valid = ($urandom_range(0, 3) != 0);
            end
            if (!contend) res_ready = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (guard >= TRAFFIC_LIMIT) chk(0, "traffic_timeout", done_ops, n_ops);
        req0_valid = 0;
        req1_valid = 0;
        res_ready  = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ta[4];
        logic [W-1:0] tb[4];
        logic [W-1:0] td[4];
        bit           tbr[4];
        bit           tid[4];
        int           g;

        clk = 0; rst_n = 0; res_ready = 1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_valid = 1; req1_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 0;
        sync();
        rst_n = 1;
        @(negedge clk);
        chk(!busy && !res_valid, "reset_flags", {busy, res_valid}, 0);
        chk(res_diff == '0 && !res_borr && !res_id, "reset_result", {res_diff, res_borr, res_id}, 0);
        sync();

        issue(1'b0, 8'h05, 8'h03);
        wait_done();
        check_obs("basic_0", 8'h02, 1'b0, 1'b0);

        ta  = '{8'h03, 8'h00, 8'h00, 8'hFF};
        tb  = '{8'h05, 8'h00, 8'hFF, 8'hFF};
        td  = '{8'hFE, 8'h00, 8'h01, 8'h00};
        tbr = '{1'b1, 1'b0, 1'b1, 1'b0};
        tid = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(tid[i], ta[i], tb[i]);
            wait_done();
            check_obs("edge_case", td[i], tbr[i], tid[i]);
        end

        do_reset();
        run_traffic(8, 1'b1);
        wait_done();

        // Consumer stall with a competing request pending
        res_ready = 0;
        req1_a = 8'h11; req1_b = 8'h22;
        issue(1'b0, 8'h5A, 8'hA5);
        req1_valid = 1;
        g = 0;
        do begin @(negedge clk); g++; end while (!res_valid && g < 50);
        if (!res_valid) chk(0, "stall_no_result", g, 0);
        repeat (4) @(negedge clk);
        chk(busy && res_valid && !req1_ready, "stall_hold", {busy, res_valid, req1_ready}, 3'b110);
        sync();
        res_ready = 1;
        g = 0;
        do begin @(negedge clk); g++; end while (!(req1_valid && req1_ready) && g < 20);
        if (!(req1_valid && req1_ready)) chk(0, "stall_regrant", g, 0);
        sync();
        req1_valid = 0;
        wait_done();
        check_obs("after_stall", 8'hEF, 1'b1, 1'b1);

        // Reset during RUN bit 4
        issue(1'b0, 8'h9C, 8'h3D);
        repeat (4) sync();
        rst_n = 0;
        sync();
        rst_n = 1;
        @(negedge clk);
        chk(!busy && !res_valid && res_diff == '0, "abort_state", {busy, res_valid, res_diff}, 0);
        sync();
        repeat (2 * W) sync();
        issue(1'b1, 8'h40, 8'h41);
        wait_done();
        check_obs("after_abort", 8'hFF, 1'b1, 1'b1);

        run_traffic(1000, 1'b0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
